// File: rtl/startmem_pkg.sv
// rtl/startmem_pkg.sv - shared types and constants for the starting memory builder
package startmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } state_t;

    // Field positions inside a record, counted in KEY_W-wide slots from the LSB
    localparam int PRIV_OFS  = 2;
    localparam int PUB_OFS   = 1;
    localparam int MONEY_OFS = 0;

    localparam int DEFAULT_INIT_MONEY = 100;

    function automatic int record_w(input int key_w);
        return 3 * key_w;
    endfunction

endpackage

// File: rtl/pearson_round.sv
// rtl/pearson_round.sv - one combinational Pearson round over the shared random table
module pearson_round #(
    parameter int KEY_W         = 8,
    parameter int TABLE_ENTRIES = 36,
    parameter int RND_W         = 2
) (
    input  logic [KEY_W-1:0]               h,
    input  logic [KEY_W-1:0]               key,
    input  logic [RND_W-1:0]               rnd,
    input  logic [TABLE_ENTRIES*KEY_W-1:0] rand_table,
    output logic [KEY_W-1:0]               next_h
);

    logic [KEY_W-1:0] mix;
    logic [31:0]      idx;

    // The modulo runs in 32 bits so a table size equal to 2**KEY_W still works
    always_comb begin
        mix    = h ^ key ^ KEY_W'(rnd);
        idx    = 32'(mix) % 32'(TABLE_ENTRIES);
        next_h = '0;
        for (int i = 0; i < TABLE_ENTRIES; i++) begin
            if (idx == 32'(i)) begin
                next_h = rand_table[KEY_W*i +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/starting_memory_builder.sv
// rtl/starting_memory_builder.sv - builds the N-player {private, public, money} image; STARTMEM_CHECKSUM_EN adds mem_checksum
module starting_memory_builder
    import startmem_pkg::*;
#(
    parameter int N_PLAYERS     = 2,
    parameter int KEY_W         = 8,
    parameter int TABLE_ENTRIES = 36,
    parameter int ROUNDS        = 4,
    parameter int INIT_MONEY    = DEFAULT_INIT_MONEY
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [N_PLAYERS*KEY_W-1:0]     private_keys,
    input  logic [TABLE_ENTRIES*KEY_W-1:0] random_table,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_valid,
    output logic [N_PLAYERS*3*KEY_W-1:0]   starting_memory
`ifdef STARTMEM_CHECKSUM_EN
    ,
    output logic [KEY_W-1:0]               mem_checksum
`endif
);

    localparam int RECORD_W = record_w(KEY_W);
    localparam int PL_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int IMG_W    = N_PLAYERS * RECORD_W;
    localparam logic [KEY_W-1:0] MONEY = KEY_W'(INIT_MONEY);

    state_t                         state;
    logic [PL_W-1:0]                player;
    logic [RND_W-1:0]               rnd;
    logic [KEY_W-1:0]               h;
    logic [N_PLAYERS*KEY_W-1:0]     keys_sh;
    logic [TABLE_ENTRIES*KEY_W-1:0] table_sh;
    logic [IMG_W-1:0]               build;
    logic [IMG_W-1:0]               build_next;
    logic [KEY_W-1:0]               key_cur;
    logic [KEY_W-1:0]               next_h;
    logic [RECORD_W-1:0]            record;
    logic                           last_round;
    logic                           last_player;

    assign last_round  = (rnd == RND_W'(ROUNDS - 1));
    assign last_player = (player == PL_W'(N_PLAYERS - 1));

    pearson_round #(
        .KEY_W         (KEY_W),
        .TABLE_ENTRIES (TABLE_ENTRIES),
        .RND_W         (RND_W)
    ) u_round (
        .h          (h),
        .key        (key_cur),
        .rnd        (rnd),
        .rand_table (table_sh),
        .next_h     (next_h)
    );

    // Player 0 sits in the MSBs of both the key bus and the image
    always_comb begin
        key_cur = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (player == PL_W'(p)) begin
                key_cur = keys_sh[KEY_W*(N_PLAYERS-p)-1 -: KEY_W];
            end
        end
        record                             = '0;
        record[PRIV_OFS*KEY_W  +: KEY_W]   = key_cur;
        record[PUB_OFS*KEY_W   +: KEY_W]   = next_h;
        record[MONEY_OFS*KEY_W +: KEY_W]   = MONEY;
        build_next = build;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (player == PL_W'(p)) begin
                build_next[RECORD_W*(N_PLAYERS-p)-1 -: RECORD_W] = record;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            player          <= '0;
            rnd             <= '0;
            h               <= '0;
            keys_sh         <= '0;
            table_sh        <= '0;
            build           <= '0;
            starting_memory <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_valid       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        keys_sh   <= private_keys;
                        table_sh  <= random_table;
                        player    <= '0;
                        rnd       <= '0;
                        h         <= '0;
                        mem_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= HASH;
                    end
                end
                HASH: begin
                    if (!last_round) begin
                        rnd <= rnd + 1'b1;
                        h   <= next_h;
                    end else begin
                        build <= build_next;
                        rnd   <= '0;
                        h     <= '0;
                        if (last_player) begin
                            // The finished image becomes visible together with the done pulse
                            player          <= '0;
                            starting_memory <= build_next;
                            done            <= 1'b1;
                            mem_valid       <= 1'b1;
                            busy            <= 1'b0;
                            state           <= DONE;
                        end else begin
                            player <= player + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STARTMEM_CHECKSUM_EN
    logic [KEY_W-1:0] csum_acc;
    logic [KEY_W-1:0] csum_next;

    assign csum_next = csum_acc ^ key_cur ^ next_h ^ MONEY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_acc     <= '0;
            mem_checksum <= '0;
        end else if (state == IDLE && start) begin
            csum_acc <= '0;
        end else if (state == HASH && last_round) begin
            csum_acc <= csum_next;
            if (last_player) begin
                mem_checksum <= csum_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_starting_memory_builder.sv
// tb/tb_starting_memory_builder.sv - bench for starting_memory_builder with ROUNDS=2 and ROUNDS=1 instances
module tb_starting_memory_builder;

    localparam int N  = 2;
    localparam int KW = 8;
    localparam int TE = 36;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start2 = 1'b0;
    logic start1 = 1'b0;
    logic [N*KW-1:0]  keys = 16'h751B;
    logic [TE*KW-1:0] tbl;

    logic             busy2, done2, valid2;
    logic             busy1, done1, valid1;
    logic [N*3*KW-1:0] mem2, mem1;
`ifdef STARTMEM_CHECKSUM_EN
    logic [KW-1:0]    csum2, csum1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    starting_memory_builder #(
        .N_PLAYERS(N), .KEY_W(KW), .TABLE_ENTRIES(TE), .ROUNDS(2), .INIT_MONEY(100)
    ) dut2 (
        .clk(clk), .reset_n(rst_n), .start(start2), .private_keys(keys), .random_table(tbl),
        .busy(busy2), .done(done2), .mem_valid(valid2), .starting_memory(mem2)
`ifdef STARTMEM_CHECKSUM_EN
        , .mem_checksum(csum2)
`endif
    );

    starting_memory_builder #(
        .N_PLAYERS(N), .KEY_W(KW), .TABLE_ENTRIES(TE), .ROUNDS(1), .INIT_MONEY(100)
    ) dut1 (
        .clk(clk), .reset_n(rst_n), .start(start1), .private_keys(keys), .random_table(tbl),
        .busy(busy1), .done(done1), .mem_valid(valid1), .starting_memory(mem1)
`ifdef STARTMEM_CHECKSUM_EN
        , .mem_checksum(csum1)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_image(input logic [15:0] k, input logic [TE*KW-1:0] t,
                                              input int rounds);
        logic [47:0] img;
        int key, h, idx;
        img = '0;
        for (int p = 0; p < N; p++) begin
            key = int'((k >> (8 * (N - 1 - p))) & 16'h00FF);
            h   = 0;
            for (int r = 0; r < rounds; r++) begin
                idx = (h ^ key ^ r) % TE;
                h   = int'(t[8*idx +: 8]);
            end
            img = (img << 24) | 48'((key << 16) | (h << 8) | 100);
        end
        return img;
    endfunction

    function automatic logic [7:0] xor_fields(input logic [47:0] img);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r ^= img[8*i +: 8];
        return r;
    endfunction

    // Reference: index 0 models the ROUNDS=2 instance, index 1 the ROUNDS=1 instance
    int          m_left [2] = '{0, 0};
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_valid[2] = '{1'b0, 1'b0};
    logic [47:0] m_mem  [2] = '{48'd0, 48'd0};
    logic [47:0] m_pend [2] = '{48'd0, 48'd0};
    logic [7:0]  m_csum [2] = '{8'd0, 8'd0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_left[d]  <= 0;
                m_busy[d]  <= 1'b0;
                m_done[d]  <= 1'b0;
                m_valid[d] <= 1'b0;
                m_mem[d]   <= '0;
                m_csum[d]  <= '0;
            end else if (m_left[d] > 0) begin
                m_left[d] <= m_left[d] - 1;
                if (m_left[d] == 1) begin
                    m_busy[d]  <= 1'b0;
                    m_done[d]  <= 1'b1;
                    m_valid[d] <= 1'b1;
                    m_mem[d]   <= m_pend[d];
                    m_csum[d]  <= xor_fields(m_pend[d]);
                end
            end else if (m_done[d]) begin
                m_done[d] <= 1'b0;
            end else if ((d == 0) ? start2 : start1) begin
                m_left[d]  <= N * ((d == 0) ? 2 : 1);
                m_busy[d]  <= 1'b1;
                m_valid[d] <= 1'b0;
                m_pend[d]  <= exp_image(keys, tbl, (d == 0) ? 2 : 1);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_r2",  64'(busy2),  64'(m_busy[0]));
        chk("done_r2",  64'(done2),  64'(m_done[0]));
        chk("valid_r2", 64'(valid2), 64'(m_valid[0]));
        chk("mem_r2",   64'(mem2),   64'(m_mem[0]));
        chk("busy_r1",  64'(busy1),  64'(m_busy[1]));
        chk("done_r1",  64'(done1),  64'(m_done[1]));
        chk("valid_r1", 64'(valid1), 64'(m_valid[1]));
        chk("mem_r1",   64'(mem1),   64'(m_mem[1]));
`ifdef STARTMEM_CHECKSUM_EN
        chk("csum_r2",  64'(csum2),  64'(m_csum[0]));
        chk("csum_r1",  64'(csum1),  64'(m_csum[1]));
`endif
    end

    task automatic run_build(input int d, input int exp_k, input logic [47:0] exp_img,
                             input string nm);
        int done_k;
        int busy_n;
        logic b, dn, v;
        logic [47:0] m;
        done_k = 0;
        busy_n = 0;
        @(negedge clk); #1;
        if (d == 0) start2 = 1'b1; else start1 = 1'b1;
        for (int k = 1; k <= 20 && done_k == 0; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin
                start2 = 1'b0;
                start1 = 1'b0;
            end
            b  = (d == 0) ? busy2  : busy1;
            dn = (d == 0) ? done2  : done1;
            v  = (d == 0) ? valid2 : valid1;
            m  = (d == 0) ? mem2   : mem1;
            if (b) busy_n++;
            if (dn) begin
                done_k = k;
                chk({nm, "_image"}, 64'(m), 64'(exp_img));
                chk({nm, "_valid"}, 64'(v), 64'd1);
            end
        end
        chk({nm, "_done_cycle"}, 64'(done_k), 64'(exp_k));
        chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(exp_k - 1));
    endtask

    initial begin
        int done_n;
        for (int i = 0; i < TE; i++) tbl[8*i +: 8] = 8'(i + 1);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy",  64'(busy2),  64'd0);
        chk("reset_valid", 64'(valid2), 64'd0);
        chk("reset_mem",   64'(mem2),   64'd0);
        rst_n = 1'b1;

        run_build(0, 5, 48'h7513641B0764, "r2_first");
`ifdef STARTMEM_CHECKSUM_EN
        chk("r2_checksum", 64'(csum2), 64'h7A);
`endif
        run_build(1, 3, 48'h750A641B1C64, "r1_first");

        // Second start and key change mid-build must not disturb the image
        done_n = 0;
        @(negedge clk); #1;
        start2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (k == 1) start2 = 1'b0;
            if (k == 2) begin
                start2 = 1'b1;
                keys   = 16'hFFFF;
            end
            if (k == 3) start2 = 1'b0;
            if (done2) begin
                done_n++;
                chk("drop_image", 64'(mem2), 64'h7513641B0764);
            end
        end
        chk("drop_done_pulses", 64'(done_n), 64'd1);
        keys = 16'h751B;

        // Abort in the second HASH cycle
        @(negedge clk); #1;
        start2 = 1'b1;
        @(negedge clk); #1;
        start2 = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy2),  64'd0);
        chk("abort_done",  64'(done2),  64'd0);
        chk("abort_valid", 64'(valid2), 64'd0);
        chk("abort_mem",   64'(mem2),   64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        run_build(0, 5, 48'h7513641B0764, "after_reset");

        // Rebuild with new keys; the old image stays visible until done
        keys = 16'h0001;
        done_n = 0;
        @(negedge clk); #1;
        start2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            if (k == 1) start2 = 1'b0;
            if (k < 5) begin
                chk("rebuild_valid_low", 64'(valid2), 64'd0);
                chk("rebuild_old_image", 64'(mem2),   64'h7513641B0764);
            end else begin
                chk("rebuild_done",      64'(done2),  64'd1);
                chk("rebuild_new_image", 64'(mem2),   64'h000164010364);
                chk("rebuild_valid",     64'(valid2), 64'd1);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
